// File: rtl/condlogic_pkg.sv
// condlogic_pkg: shared definitions for the condition logic with IT support.
//   - ARM condition-code constants (EQ..AL, NV)
//   - it_state_t: IT sequencer states
//   - cond_inv(): condition used by "else" slots of an IT block
//   - bit positions of N, Z, C, V inside the 4-bit flags vector
package condlogic_pkg;

  localparam logic [3:0] EQ = 4'b0000;
  localparam logic [3:0] NE = 4'b0001;
  localparam logic [3:0] CS = 4'b0010;
  localparam logic [3:0] CC = 4'b0011;
  localparam logic [3:0] MI = 4'b0100;
  localparam logic [3:0] PL = 4'b0101;
  localparam logic [3:0] VS = 4'b0110;
  localparam logic [3:0] VC = 4'b0111;
  localparam logic [3:0] HI = 4'b1000;
  localparam logic [3:0] LS = 4'b1001;
  localparam logic [3:0] GE = 4'b1010;
  localparam logic [3:0] LT = 4'b1011;
  localparam logic [3:0] GT = 4'b1100;
  localparam logic [3:0] LE = 4'b1101;
  localparam logic [3:0] AL = 4'b1110;
  localparam logic [3:0] NV = 4'b1111;

  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

  typedef enum logic [0:0] {
    IT_IDLE = 1'b0,
    IT_RUN  = 1'b1
  } it_state_t;

  // Inverse condition: flipping bit 0 pairs EQ/NE, CS/CC, ... .
  // AL has no meaningful inverse and NV is never used as one, so both map to AL.
  function automatic logic [3:0] cond_inv(input logic [3:0] c);
    if (c == AL || c == NV) return AL;
    return {c[3:1], ~c[0]};
  endfunction

endpackage

// File: rtl/condcheck.sv
// condcheck: combinational ARM condition evaluation.
//   Cond   in  4  condition field
//   Flags  in  4  {N,Z,C,V}
//   CondEx out 1  condition holds
// NV (1111) never executes.
module condcheck
  import condlogic_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v, ge;

  always_comb begin
    n  = Flags[N_BIT];
    z  = Flags[Z_BIT];
    c  = Flags[C_BIT];
    v  = Flags[V_BIT];
    ge = (n == v);
    case (Cond)
      EQ:      CondEx = z;
      NE:      CondEx = ~z;
      CS:      CondEx = c;
      CC:      CondEx = ~c;
      MI:      CondEx = n;
      PL:      CondEx = ~n;
      VS:      CondEx = v;
      VC:      CondEx = ~v;
      HI:      CondEx = c & ~z;
      LS:      CondEx = ~(c & ~z);
      GE:      CondEx = ge;
      LT:      CondEx = ~ge;
      GT:      CondEx = ~z & ge;
      LE:      CondEx = ~(~z & ge);
      AL:      CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/condlogic_it_seq.sv
// it_seq: IT-block sequencer. Holds the block's base condition, then/else
// mask, slot index and remaining count, and selects the effective condition.
//   clk, reset         clock, async active-low reset
//   ITLoad/ITCond/ITMask/ITCount  block load request and contents
//   InstrDone          current instruction retired (advances a slot)
//   Cond               instruction's own condition (used outside a block)
//   it_active          block in progress (state == IT_RUN)
//   it_idx             current slot index
//   eff_cond           condition to evaluate this cycle
//   ITErr              (CONDLOGIC_ITERR_EN only) one-cycle pulse after an ignored load
module it_seq
  import condlogic_pkg::*;
#(
  parameter int IT_DEPTH = 4,
  parameter int CW       = $clog2(IT_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ITLoad,
  input  logic [3:0]          ITCond,
  input  logic [IT_DEPTH-1:0] ITMask,
  input  logic [CW-1:0]       ITCount,
  input  logic                InstrDone,
  input  logic [3:0]          Cond,
  output logic                it_active,
  output logic [CW-1:0]       it_idx,
  output logic [3:0]          eff_cond
`ifdef CONDLOGIC_ITERR_EN
  , output logic              ITErr
`endif
);

  localparam logic [CW-1:0] DEPTH_C = CW'(IT_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  it_state_t           state_q, state_d;
  logic [CW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       rem_q, rem_d;
  logic [IT_DEPTH-1:0] mask_q, mask_d;
  logic [3:0]          cond_q, cond_d;
  logic                count_ok, load_ok;
  logic [IT_DEPTH-1:0] mask_sh;

  assign count_ok = (ITCount != '0) && (ITCount <= DEPTH_C);
  // A load is only taken from idle; nested loads are dropped.
  assign load_ok  = ITLoad && (state_q == IT_IDLE) && count_ok;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    mask_d  = mask_q;
    cond_d  = cond_q;
    case (state_q)
      IT_IDLE: begin
        // Load wins over a same-cycle InstrDone, which has no effect here.
        if (load_ok) begin
          cond_d  = ITCond;
          mask_d  = ITMask;
          rem_d   = ITCount;
          idx_d   = '0;
          state_d = IT_RUN;
        end
      end
      IT_RUN: begin
        // A failed predicated slot still retires and consumes its slot.
        if (InstrDone) begin
          if (rem_q == ONE_C) begin
            state_d = IT_IDLE;
            idx_d   = '0;
            rem_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
            rem_d = rem_q - 1'b1;
          end
        end
      end
      default: state_d = IT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IT_IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      mask_q  <= '0;
      cond_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      mask_q  <= mask_d;
      cond_q  <= cond_d;
    end
  end

  assign it_active = (state_q == IT_RUN);
  assign it_idx    = idx_q;
  assign mask_sh   = mask_q >> idx_q;
  assign eff_cond  = it_active ? (mask_sh[0] ? cond_q : cond_inv(cond_q)) : Cond;

`ifdef CONDLOGIC_ITERR_EN
  logic err_q, err_d;
  assign err_d = ITLoad && !load_ok;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign ITErr = err_q;
`endif

endmodule

// File: rtl/condlogic_it.sv
// condlogic_it: multi-cycle ARM condition logic with grouped flag writes and
// an IT-block sequencer predicating up to IT_DEPTH following instructions.
// Optional macro CONDLOGIC_ITERR_EN adds the ITErr output.
//   clk, reset (async active-low)
//   Cond, ALUFlags, FlagW[NGROUPS], PCS, NextPC, RegW, MemW  decode/datapath inputs
//   InstrDone, ITLoad, ITCond, ITMask, ITCount               IT control
//   PCWrite, RegWrite, MemWrite  qualified write enables
//   Flags                        current {N,Z,C,V}
//   ITActive, ITIdx              IT block status
//   ITErr (optional)             pulse after an ignored IT load
module condlogic_it
  import condlogic_pkg::*;
#(
  parameter int NGROUPS  = 2,
  parameter int IT_DEPTH = 4,
  parameter int CW       = $clog2(IT_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          Cond,
  input  logic [3:0]          ALUFlags,
  input  logic [NGROUPS-1:0]  FlagW,
  input  logic                PCS,
  input  logic                NextPC,
  input  logic                RegW,
  input  logic                MemW,
  input  logic                InstrDone,
  input  logic                ITLoad,
  input  logic [3:0]          ITCond,
  input  logic [IT_DEPTH-1:0] ITMask,
  input  logic [CW-1:0]       ITCount,
  output logic                PCWrite,
  output logic                RegWrite,
  output logic                MemWrite,
  output logic [3:0]          Flags,
  output logic                ITActive,
  output logic [CW-1:0]       ITIdx
`ifdef CONDLOGIC_ITERR_EN
  , output logic              ITErr
`endif
);

  logic [3:0]         eff_cond;
  logic               cond_ex;
  logic [NGROUPS-1:0] flag_write;
  logic [3:0]         bit_we;
  logic [3:0]         flags_q, flags_d;
  logic               cond_ex_next_q, cond_ex_next_d;

  it_seq #(.IT_DEPTH(IT_DEPTH), .CW(CW)) u_it_seq (
    .clk       (clk),
    .reset     (reset),
    .ITLoad    (ITLoad),
    .ITCond    (ITCond),
    .ITMask    (ITMask),
    .ITCount   (ITCount),
    .InstrDone (InstrDone),
    .Cond      (Cond),
    .it_active (ITActive),
    .it_idx    (ITIdx),
    .eff_cond  (eff_cond)
`ifdef CONDLOGIC_ITERR_EN
    , .ITErr   (ITErr)
`endif
  );

  condcheck u_condcheck (
    .Cond   (eff_cond),
    .Flags  (flags_q),
    .CondEx (cond_ex)
  );

  assign flag_write = FlagW & {NGROUPS{cond_ex}};

  // Expand group enables to per-bit enables: flag bit b belongs to group b*NGROUPS/4.
  for (genvar b = 0; b < 4; b++) begin : g_bit_we
    assign bit_we[b] = flag_write[b * NGROUPS / 4];
  end

  always_comb begin
    flags_d        = (flags_q & ~bit_we) | (ALUFlags & bit_we);
    cond_ex_next_d = cond_ex;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q        <= '0;
      cond_ex_next_q <= 1'b0;
    end else begin
      flags_q        <= flags_d;
      cond_ex_next_q <= cond_ex_next_d;
    end
  end

  assign Flags    = flags_q;
  assign RegWrite = RegW & cond_ex_next_q;
  assign MemWrite = MemW & cond_ex_next_q;
  // NextPC is the unconditional fetch update and bypasses the condition.
  assign PCWrite  = (PCS & cond_ex_next_q) | NextPC;

endmodule

// File: doc/condlogic_it.md
Name: condlogic_it

Overview:
- Parametrised successor of the multi-cycle condition logic.
- Holds the NZCV flags in NGROUPS independently writable groups.
- Evaluates the ARM condition and qualifies PC, register and memory writes.
- Adds a Thumb-style IT-block sequencer, so up to IT_DEPTH following instructions are predicated on a loaded condition/then-else mask instead of their own Cond field.

Parameters:
- NGROUPS, 2, number of flag write-enable groups; legal values 1, 2, 4; group g covers Flags[(g+1)*4/NGROUPS-1 : g*4/NGROUPS].
- IT_DEPTH, 4, maximum instructions in one IT block (1..8).
- CW, $clog2(IT_DEPTH+1), derived width of count fields.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Cond  in  4  condition field of the current instruction.
- ALUFlags  in  4  {N,Z,C,V} from the ALU.
- FlagW  in  NGROUPS  per-group flag write request from decode.
- PCS  in  1  instruction writes PC.
- NextPC  in  1  unconditional PC update (fetch).
- RegW  in  1  register write request.
- MemW  in  1  memory write request.
- InstrDone  in  1  one-cycle pulse; the current instruction has retired.
- ITLoad  in  1  one-cycle pulse; start an IT block.
- ITCond  in  4  base condition of the IT block.
- ITMask  in  IT_DEPTH  bit i=1: instruction i uses ITCond; 0: uses inverse.
- ITCount  in  CW  number of instructions in the block.
- PCWrite  out  1  update PC.
- RegWrite  out  1  register write enable.
- MemWrite  out  1  memory write enable.
- Flags  out  4  current {N,Z,C,V}.
- ITActive  out  1  IT block in progress.
- ITIdx  out  CW  index of the current predicated instruction.

Behaviour:
- Reset (async, reset=0):
  - Flags=0, CondExNext=0, state IT_IDLE.
  - ITIdx=0, remaining=0, stored mask/cond=0.
  - All write outputs 0 except PCWrite=NextPC.
- Effective condition EffCond:
  - If ITActive: ITMask_q[ITIdx] ? ITCond_q : inv(ITCond_q).
  - Otherwise: Cond.
  - inv(c) flips c[0]. For c=1110 (AL), inv keeps 1110. For c=1111, inv is treated as AL.
- CondEx = condcheck(EffCond, Flags), combinational, standard ARM encodings.
- FlagWrite[g] = FlagW[g] & CondEx. Enabled groups load their ALUFlags slice at the clock edge.
- CondExNext register samples CondEx every cycle (one-cycle latency).
  - RegWrite = RegW & CondExNext.
  - MemWrite = MemW & CondExNext.
  - PCWrite = (PCS & CondExNext) | NextPC.
- IT FSM, states IT_IDLE and IT_RUN:
  - IT_IDLE + ITLoad with 1 <= ITCount <= IT_DEPTH: capture ITCond, ITMask, ITCount into remaining; ITIdx=0; go to IT_RUN next cycle.
  - IT_IDLE + ITLoad with ITCount=0 or ITCount>IT_DEPTH: ignored, stay IT_IDLE.
  - IT_IDLE + InstrDone: no effect.
  - Same-cycle ITLoad and InstrDone in IT_IDLE: the load wins.
  - IT_RUN + InstrDone: ITIdx+1, remaining-1.
  - IT_RUN + InstrDone with remaining=1: go to IT_IDLE, ITIdx=0.
  - IT_RUN + ITLoad: ignored. A nested IT is illegal.
  - ITActive = (state == IT_RUN), registered.
  - A predicated instruction whose condition fails still consumes a slot on InstrDone.
- Flags written inside an IT block affect later slots' CondEx on the next cycle; no bypass.
- Reset mid-block aborts it immediately: IT_IDLE, stored mask cleared.

Optional Feature:
- Macro: CONDLOGIC_ITERR_EN.
- Defined:
  - Adds output ITErr (1 bit, registered, reset 0).
  - ITErr pulses high for exactly one cycle after any ignored ITLoad (bad count, or load in IT_RUN).
- Undefined:
  - No ITErr port; illegal loads are silently dropped.
  - All other behaviour is identical.

Decomposition:
- Package condlogic_pkg holds:
  - Condition-code localparams: EQ..AL, NV.
  - Enum it_state_t {IT_IDLE, IT_RUN}.
  - Function cond_inv.
  - Flag bit-index constants N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0.
- Existing condcheck is instantiated unchanged.
- One new sub-module, it_seq: the IT FSM, counters and stored mask/cond. It outputs ITActive, ITIdx and the selected EffCond.
- Flag registers and output qualification stay in the top module.

Test Plan:
- Reset/basic write:
  - reset=0 then 1; ALUFlags=0100, FlagW=11, Cond=1110 → Flags=0100 next cycle.
  - Then Cond=0000 (EQ), RegW=1 → RegWrite=1 one cycle later.
- Group granularity:
  - NGROUPS=2, Flags=0000, ALUFlags=1111, FlagW=01, Cond=AL → Flags=0011.
  - Same stimulus with Cond=0000 and Z=0 → Flags unchanged.
- IT sequencing:
  - Flags Z=1; ITLoad, ITCond=0000, ITMask=0101, ITCount=3.
  - Three InstrDone pulses with RegW=1 → RegWrite pattern 1,0,1.
  - ITActive drops after the third pulse; ITIdx returns to 0.
- Illegal loads (macro on):
  - ITLoad with ITCount=0 → ITErr=1 for one cycle, ITActive stays 0.
  - ITLoad while IT_RUN → ITErr=1, ITIdx unchanged.
- Reset mid-block: after ITLoad (count 4) and one InstrDone, assert reset → ITActive=0, ITIdx=0, Flags=0 asynchronously.
- Unconditional fetch: NextPC=1, PCS=0, condition false → PCWrite=1. PCS=1 with a failed condition and NextPC=0 → PCWrite=0.
